prog_write_arbiter: RTL and testbench
=====================================

Name: prog_write_arbiter

Overview:
- Owns the single write port of the 16x8 program memory and shares it between three writers: the CPU (WE/MI path), the UART loader (serial strobes) and the manual switch/KEY programmer.
- Sequences RUN/PROGRAM mode changes with a guard cycle and drains pending loader writes before returning to RUN.
- Sits between the memory block and its write sources; presents registered, glitch-free mem_we/mem_addr/mem_data.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- SER_DEPTH, 2, serial pending FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- prog_mode  in  1  1 = PROGRAM requested (SW[5]), 0 = RUN
- cpu_we  in  1  CPU write request, level, one write per cycle asserted
- cpu_addr  in  ADDR_W  CPU write address
- cpu_data  in  DATA_W  CPU write data
- ser_we  in  1  serial write strobe, single-cycle pulse
- ser_addr  in  ADDR_W  serial address, valid with ser_we
- ser_data  in  DATA_W  serial data, valid with ser_we
- man_we  in  1  manual write button, debounced level, active-high
- man_addr  in  ADDR_W  switch address
- man_data  in  DATA_W  switch data
- mem_we  out  1  registered memory write enable
- mem_addr  out  ADDR_W  registered write address
- mem_data  out  DATA_W  registered write data
- cpu_stall  out  1  CPU write blocked this cycle
- in_prog  out  1  arbiter is in PROGRAM-side states
- busy  out  1  state != ST_RUN, or FIFO non-empty, or manual pending
- ser_ovf  out  1  sticky serial overflow flag

Behaviour:
- Reset: state = ST_RUN; FIFO empty; man_pend = 0; mem_we = 0; mem_addr = 0; mem_data = 0; ser_ovf = 0; cpu_stall = 0; in_prog = 0; the man_we edge-detect register = 0.
- States:
  - ST_RUN: on prog_mode = 1 -> ST_TO_PROG.
  - ST_TO_PROG: one guard cycle, no writes -> ST_PROG.
  - ST_PROG: on prog_mode = 0 -> ST_DRAIN.
  - ST_DRAIN: returns to ST_PROG if prog_mode rises again. Otherwise -> ST_TO_RUN once FIFO is empty and man_pend = 0.
  - ST_TO_RUN: one guard cycle, no writes -> ST_RUN.
- in_prog = 1 in ST_TO_PROG, ST_PROG, ST_DRAIN, ST_TO_RUN.
- Latency: every granted write appears on mem_* exactly one cycle after selection. mem_we is high for exactly one cycle per write. mem_addr/mem_data hold their last value when mem_we = 0.
- RUN:
  - cpu_we at cycle n -> mem_we = 1 at n+1 with the cycle-n addr/data.
  - cpu_stall = 0.
  - Serial strobes are still enqueued, not written. Manual edges are ignored.
- cpu_stall = cpu_we in every state except ST_RUN. Stalled CPU writes are never performed.
- Serial FIFO:
  - Push on ser_we in any state.
  - Pop only when the serial source is granted in ST_PROG/ST_DRAIN.
  - Push and pop in the same cycle are both legal when full.
  - Push while full with no same-cycle pop: the entry is dropped and ser_ovf is set. ser_ovf clears only on rst.
- Manual:
  - A rising edge of man_we while in_prog captures man_addr/man_data and sets man_pend.
  - A new edge while pending overwrites the captured addr/data; newest wins, and only one write results.
  - man_pend clears when the manual source is granted.
- Arbitration in ST_PROG/ST_DRAIN: at most one grant per cycle. Default is fixed priority, serial over manual.
- Entries enqueued during RUN are written after entering PROGRAM, in FIFO order.
- rst mid-operation discards FIFO contents, the pending manual write and any in-flight mem_we.

Optional Feature:
- Macro: PROG_ARB_RR_EN.
- Defined: round-robin between serial and manual. The last-granted source has lower priority next time both request. The pointer resets to favour serial.
- Undefined: fixed priority, serial over manual. Manual can starve under continuous serial traffic.

Decomposition:
- Shared package (prog_arb_pkg):
  - State enum: ST_RUN, ST_TO_PROG, ST_PROG, ST_DRAIN, ST_TO_RUN.
  - Source-select encoding: SRC_NONE, SRC_CPU, SRC_SER, SRC_MAN.
  - Default widths ADDR_W/DATA_W.
- One sub-module: prog_wr_fifo. Synchronous FIFO of {addr, data} with push, pop, full, empty, parameterised by SER_DEPTH.

Test Plan:
- RUN: cpu_we = 1, addr = 3, data = 0x2A for one cycle -> next cycle mem_we = 1, mem_addr = 3, mem_data = 0x2A; cpu_stall = 0.
- Mode entry: prog_mode 0->1 while cpu_we = 1 -> one guard cycle with mem_we = 0, then in_prog = 1; cpu_stall = 1 from the ST_TO_PROG cycle onward, and no CPU write is performed.
- Serial burst: in ST_PROG, three back-to-back ser_we (addr 0/1/2, data 0x11/0x22/0x33) -> three consecutive mem_we pulses in order 0x11, 0x22, 0x33; ser_ovf = 0.
- Overflow: in RUN with SER_DEPTH = 2, three ser_we strobes -> ser_ovf = 1. After entering PROGRAM, only entries 0 and 1 are written.
- Contention: in ST_PROG, man_we rising edge (addr 5, data 0x55) in the same cycle as ser_we (addr 6, data 0x66) -> addr 6 written first, addr 5 next cycle. In a second collision with PROG_ARB_RR_EN defined, manual wins.
- Drain/reset: prog_mode 1->0 with 2 FIFO entries -> both written, then ST_TO_RUN then ST_RUN, busy falls. Repeat with rst asserted mid-drain -> next cycle mem_we = 0, busy = 0, state ST_RUN, no further writes.

Source files
------------

// File: rtl/prog_arb_pkg.sv
// Shared types for the program-memory write arbiter: FSM states,
// write-source select encoding and default bus widths.
package prog_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_TO_PROG,
        ST_PROG,
        ST_DRAIN,
        ST_TO_RUN
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_CPU,
        SRC_SER,
        SRC_MAN
    } src_t;

    // Every state other than RUN belongs to the PROGRAM side.
    function automatic logic is_prog_side(state_t s);
        return s != ST_RUN;
    endfunction

    // Only these two states may hand the port to the serial or manual source.
    function automatic logic is_prog_grant(state_t s);
        return (s == ST_PROG) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/prog_write_arbiter_if.sv
// Bundle of write-source inputs, the memory write port and status flags.
// The slave modport is the arbiter's view; the master modport is the
// view of whatever drives the sources and watches the memory port.
interface prog_write_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              prog_mode;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;
    logic              ser_we;
    logic [ADDR_W-1:0] ser_addr;
    logic [DATA_W-1:0] ser_data;
    logic              man_we;
    logic [ADDR_W-1:0] man_addr;
    logic [DATA_W-1:0] man_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_stall;
    logic              in_prog;
    logic              busy;
    logic              ser_ovf;

    modport slave (
        input  prog_mode, cpu_we, cpu_addr, cpu_data,
               ser_we, ser_addr, ser_data,
               man_we, man_addr, man_data,
        output mem_we, mem_addr, mem_data,
               cpu_stall, in_prog, busy, ser_ovf
    );

    modport master (
        output prog_mode, cpu_we, cpu_addr, cpu_data,
               ser_we, ser_addr, ser_data,
               man_we, man_addr, man_data,
        input  mem_we, mem_addr, mem_data,
               cpu_stall, in_prog, busy, ser_ovf
    );

endinterface

// File: rtl/prog_wr_fifo.sv
// Small synchronous FIFO of {addr, data} pairs holding serial-loader
// writes until the arbiter can grant them. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module prog_wr_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] pop_addr,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W+DATA_W-1:0] store [DEPTH];
    logic [PW:0]              wr_ptr;
    logic [PW:0]              rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    // Extra pointer bit tells full from empty when the indexes coincide.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                     (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign {pop_addr, pop_data} = store[rd_ptr[PW-1:0]];

    // Pointer update; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end
    end

    // Entry storage; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr[PW-1:0]] <= {push_addr, push_data};
    end

endmodule

// File: rtl/prog_write_arbiter.sv
// Owner of the program-memory write port. Shares it between the CPU
// (RUN only), the serial loader (queued) and the manual programmer
// (edge-captured), sequencing RUN/PROGRAM changes through guard states.
// Optional feature: define PROG_ARB_RR_EN for round-robin between the
// serial and manual sources; otherwise serial has fixed priority.
module prog_write_arbiter
    import prog_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SER_DEPTH = 2
) (
    input logic                 clk,
    input logic                 rst,
    prog_write_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    src_t              sel;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [ADDR_W-1:0] fifo_addr;
    logic [DATA_W-1:0] fifo_data;

    logic              man_q;
    logic              man_edge;
    logic              man_pend;
    logic [ADDR_W-1:0] man_addr_q;
    logic [DATA_W-1:0] man_data_q;

    logic              ser_req;
    logic              man_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              ovf_q;

`ifdef PROG_ARB_RR_EN
    // Set when serial won the most recent contended grant.
    logic              rr_last_ser;
`endif

    assign ser_req  = !fifo_empty;
    assign man_req  = man_pend;
    assign fifo_pop = (sel == SRC_SER);
    assign man_edge = bus.man_we && !man_q;

    prog_wr_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (SER_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.ser_we),
        .push_addr (bus.ser_addr),
        .push_data (bus.ser_data),
        .pop       (fifo_pop),
        .pop_addr  (fifo_addr),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // Next state and write-source grant.
    always_comb begin
        state_nxt = state;
        sel       = SRC_NONE;
        case (state)
            ST_RUN: begin
                if (bus.cpu_we)    sel       = SRC_CPU;
                if (bus.prog_mode) state_nxt = ST_TO_PROG;
            end
            ST_TO_PROG: state_nxt = ST_PROG;
            ST_PROG: begin
                if (!bus.prog_mode) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.prog_mode)                state_nxt = ST_PROG;
                else if (fifo_empty && !man_pend) state_nxt = ST_TO_RUN;
            end
            ST_TO_RUN: state_nxt = ST_RUN;
            default:   state_nxt = ST_RUN;
        endcase

        if (is_prog_grant(state)) begin
`ifdef PROG_ARB_RR_EN
            if (ser_req && man_req) sel = rr_last_ser ? SRC_MAN : SRC_SER;
            else if (ser_req)       sel = SRC_SER;
            else if (man_req)       sel = SRC_MAN;
`else
            if (ser_req)      sel = SRC_SER;
            else if (man_req) sel = SRC_MAN;
`endif
        end
    end

    // Address/data of the granted source.
    always_comb begin
        wr_addr = mem_addr_q;
        wr_data = mem_data_q;
        case (sel)
            SRC_CPU: begin wr_addr = bus.cpu_addr; wr_data = bus.cpu_data;   end
            SRC_SER: begin wr_addr = fifo_addr;    wr_data = fifo_data;      end
            SRC_MAN: begin wr_addr = man_addr_q;   wr_data = man_data_q;     end
            default: begin wr_addr = mem_addr_q;   wr_data = mem_data_q;     end
        endcase
    end

    // Registered memory port: one-cycle write pulse, address/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            mem_we_q   <= (sel != SRC_NONE);
            mem_addr_q <= wr_addr;
            mem_data_q <= wr_data;
        end
    end

    // Manual capture: a new edge overrides a same-cycle grant so the
    // newest switch setting is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            man_q      <= 1'b0;
            man_pend   <= 1'b0;
            man_addr_q <= '0;
            man_data_q <= '0;
        end else begin
            man_q <= bus.man_we;
            if (man_edge && is_prog_side(state)) begin
                man_pend   <= 1'b1;
                man_addr_q <= bus.man_addr;
                man_data_q <= bus.man_data;
            end else if (sel == SRC_MAN) begin
                man_pend   <= 1'b0;
            end
        end
    end

    // Sticky overflow: a strobe dropped because the FIFO stayed full.
    always_ff @(posedge clk) begin
        if (rst)                                         ovf_q <= 1'b0;
        else if (bus.ser_we && fifo_full && !fifo_pop)   ovf_q <= 1'b1;
    end

`ifdef PROG_ARB_RR_EN
    // Round-robin pointer moves only on contended grants.
    always_ff @(posedge clk) begin
        if (rst)                   rr_last_ser <= 1'b0;
        else if (ser_req && man_req && sel != SRC_NONE)
                                   rr_last_ser <= (sel == SRC_SER);
    end
`endif

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.cpu_stall = bus.cpu_we && (state != ST_RUN);
    assign bus.in_prog   = is_prog_side(state);
    assign bus.busy      = (state != ST_RUN) || !fifo_empty || man_pend;
    assign bus.ser_ovf   = ovf_q;

endmodule

// File: tb/tb_prog_write_arbiter.sv
// Self-checking bench for prog_write_arbiter: directed steps plus
// randomized traffic compared every cycle against a transaction-level
// reference model (queue of loader writes, one pending manual write).
`timescale 1ns/1ps
module tb_prog_write_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    prog_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .SER_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. mode: 0 run, 1 entering program, 2 program,
    // 3 draining, 4 returning to run.
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           q[$];
    int            mode;
    bit            pend;
    logic [AW-1:0] p_a;
    logic [DW-1:0] p_d;
    bit            m_prev;
    bit            ovf;
    bit            ser_won_last;
    bit            e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    int            writes;

    task automatic model_reset();
        q.delete();
        mode = 0; pend = 0; p_a = '0; p_d = '0; m_prev = 0; ovf = 0;
        ser_won_last = 0; e_we = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_clock();
        bit  q_was_empty, pend_was, take_ser, take_man;
        wr_t w;
        q_was_empty = (q.size() == 0);
        pend_was    = pend;
        take_ser = 0; take_man = 0;
        e_we = 0;
        if (mode == 0 && bus.cpu_we) begin
            e_we = 1; e_addr = bus.cpu_addr; e_data = bus.cpu_data;
        end else if (mode == 2 || mode == 3) begin
`ifdef PROG_ARB_RR_EN
            if (!q_was_empty && pend_was) begin
                take_ser = !ser_won_last; take_man = ser_won_last;
                ser_won_last = take_ser;
            end else begin
                take_ser = !q_was_empty; take_man = q_was_empty && pend_was;
            end
`else
            take_ser = !q_was_empty; take_man = q_was_empty && pend_was;
`endif
            if (take_ser) begin
                w = q.pop_front();
                e_we = 1; e_addr = w.a; e_data = w.d;
            end
            if (take_man) begin
                pend = 0; e_we = 1; e_addr = p_a; e_data = p_d;
            end
        end
        if (e_we) writes++;
        if (bus.ser_we) begin
            if (q.size() < DEPTH) begin
                w.a = bus.ser_addr; w.d = bus.ser_data; q.push_back(w);
            end else ovf = 1;
        end
        if (bus.man_we && !m_prev && mode != 0) begin
            pend = 1; p_a = bus.man_addr; p_d = bus.man_data;
        end
        m_prev = bus.man_we;
        case (mode)
            0: if (bus.prog_mode) mode = 1;
            1: mode = 2;
            2: if (!bus.prog_mode) mode = 3;
            3: if (bus.prog_mode) mode = 2;
               else if (q_was_empty && !pend_was) mode = 4;
            default: mode = 0;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_clock();
        #1;
        chk("mem_we",    32'(bus.mem_we),    32'(e_we));
        chk("mem_addr",  32'(bus.mem_addr),  32'(e_addr));
        chk("mem_data",  32'(bus.mem_data),  32'(e_data));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_we && mode != 0));
        chk("in_prog",   32'(bus.in_prog),   32'(mode != 0));
        chk("busy",      32'(bus.busy),      32'(mode != 0 || q.size() != 0 || pend));
        chk("ser_ovf",   32'(bus.ser_ovf),   32'(ovf));
    endtask

    task automatic ser(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.ser_we = 1; bus.ser_addr = a; bus.ser_data = d;
    endtask

    task automatic quiet();
        bus.cpu_we = 0; bus.ser_we = 0;
    endtask

    initial begin
        int w0;
        bus.prog_mode = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
        bus.ser_we = 0; bus.ser_addr = '0; bus.ser_data = '0;
        bus.man_we = 0; bus.man_addr = '0; bus.man_data = '0;
        writes = 0;
        model_reset();

        // Reset state.
        rst = 1; step(); step();
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_busy",   32'(bus.busy),   0);
        rst = 0;

        // RUN: CPU write passes through with one cycle latency.
        bus.cpu_we = 1; bus.cpu_addr = 4'd3; bus.cpu_data = 8'h2A; step();
        chk("run_addr", 32'(bus.mem_addr), 3);
        chk("run_data", 32'(bus.mem_data), 32'h2A);
        for (int i = 0; i < 8; i++) begin
            bus.cpu_we = 1'($urandom); bus.cpu_addr = 4'($urandom);
            bus.cpu_data = 8'($urandom); step();
        end
        quiet(); step();

        // Overflow in RUN: third strobe is dropped.
        ser(4'd0, 8'hA0); step(); ser(4'd1, 8'hA1); step(); ser(4'd2, 8'hA2); step();
        quiet(); step();
        chk("ovf_set", 32'(bus.ser_ovf), 1);

        // Mode entry with CPU still requesting; queued entries drain.
        w0 = writes;
        bus.cpu_we = 1; bus.cpu_addr = 4'd9; bus.cpu_data = 8'h99; bus.prog_mode = 1;
        for (int i = 0; i < 6; i++) step();
        chk("entry_writes", 32'(writes - w0), 3);
        quiet(); step();

        // Fresh start, enter PROGRAM.
        rst = 1; step(); rst = 0;
        bus.prog_mode = 1; for (int i = 0; i < 3; i++) step();

        // Serial burst of three back-to-back strobes.
        ser(4'd0, 8'h11); step(); ser(4'd1, 8'h22); step(); ser(4'd2, 8'h33); step();
        quiet(); for (int i = 0; i < 3; i++) step();
        chk("burst_data_last", 32'(bus.mem_data), 32'h33);

        // Manual/serial collision, twice.
        for (int k = 0; k < 2; k++) begin
            bus.man_we = 1; bus.man_addr = 4'd5; bus.man_data = 8'h55; ser(4'd6, 8'h66);
            step(); quiet(); for (int i = 0; i < 3; i++) step();
            bus.man_we = 0; step();
        end

        // Randomized PROGRAM-side traffic.
        for (int i = 0; i < 60; i++) begin
            bus.ser_we = ($urandom_range(0, 2) == 0);
            bus.ser_addr = 4'($urandom); bus.ser_data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.man_we = !bus.man_we;
            bus.man_addr = 4'($urandom); bus.man_data = 8'($urandom);
            bus.cpu_we = 1'($urandom);
            step();
        end
        quiet(); bus.man_we = 0; for (int i = 0; i < 4; i++) step();

        // Drain with two entries queued, then back to RUN.
        rst = 1; step(); rst = 0;
        bus.prog_mode = 1; for (int i = 0; i < 3; i++) step();
        bus.prog_mode = 0; ser(4'd7, 8'h77); step(); ser(4'd8, 8'h88); step();
        quiet(); for (int i = 0; i < 6; i++) step();
        chk("drain_busy", 32'(bus.busy), 0);

        // Reset in the middle of a drain.
        bus.prog_mode = 1; for (int i = 0; i < 3; i++) step();
        bus.prog_mode = 0; ser(4'd1, 8'hE1); step(); ser(4'd2, 8'hE2); step();
        quiet(); rst = 1; step(); rst = 0;
        chk("mid_rst_we",   32'(bus.mem_we),  0);
        chk("mid_rst_busy", 32'(bus.busy),    0);
        for (int i = 0; i < 3; i++) step();

        // Fully random traffic including mode changes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) bus.prog_mode = !bus.prog_mode;
            bus.cpu_we = 1'($urandom); bus.cpu_addr = 4'($urandom); bus.cpu_data = 8'($urandom);
            bus.ser_we = ($urandom_range(0, 3) == 0);
            bus.ser_addr = 4'($urandom); bus.ser_data = 8'($urandom);
            if ($urandom_range(0, 3) == 0) bus.man_we = !bus.man_we;
            bus.man_addr = 4'($urandom); bus.man_data = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0; quiet(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
